alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_req_slot.sv | 63 ++++++
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: items shared by the ALU sequencer and its request buffer.
//   OP_BITS  - width of the ALU operation code
//   OP_*     - ALU operation codes
//   state_t  - sequencer FSM state encoding
package alu_pkg;

    localparam int OP_BITS = 3;

    localparam logic [OP_BITS-1:0] OP_ADD = 3'd0;
    localparam logic [OP_BITS-1:0] OP_ADC = 3'd1;
    localparam logic [OP_BITS-1:0] OP_SUB = 3'd2;
    localparam logic [OP_BITS-1:0] OP_SBC = 3'd3;
    localparam logic [OP_BITS-1:0] OP_AND = 3'd4;
    localparam logic [OP_BITS-1:0] OP_XOR = 3'd5;
    localparam logic [OP_BITS-1:0] OP_OR  = 3'd6;
    localparam logic [OP_BITS-1:0] OP_CP  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_req_slot.sv
// alu_req_slot: two-entry in-order request buffer (active + pending).
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   push           - store push_data (caller only pushes while ready=1)
//   push_data      - packed request word
//   pop            - the active request has finished (completed or dropped)
//   active_data    - request currently being executed
//   pending_valid  - pending entry occupied
//   ready          - pending entry free, a push can be taken
// On pop the pending entry (if any) moves to active in the same edge; with no
// pending entry a simultaneous push goes straight to active, so the
// sequencer never sees a bubble between back-to-back operations.
module alu_req_slot
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] active_data,
    output logic         pending_valid,
    output logic         ready
);

    logic         active_valid;
    logic [W-1:0] pending_data;

    assign ready = !pending_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_valid  <= 1'b0;
            active_data   <= '0;
            pending_valid <= 1'b0;
            pending_data  <= '0;
        end else if (!active_valid) begin
            if (push) begin
                active_valid <= 1'b1;
                active_data  <= push_data;
            end
        end else if (pop) begin
            if (pending_valid) begin
                // pending is promoted first, then a same-cycle push refills it
                active_data   <= pending_data;
                pending_valid <= push;
                if (push) begin
                    pending_data <= push_data;
                end
            end else if (push) begin
                active_data <= push_data;
            end else begin
                active_valid <= 1'b0;
            end
        end else if (push) begin
            pending_valid <= 1'b1;
            pending_data  <= push_data;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: feeds queued ALU operation requests to a multi-cycle ALU.
// Ports:
//   clk, reset_n              - clock, asynchronous active-low reset
//   req_*                     - operation request (valid/ready), fields + tag
//   mem_valid                 - memory operand data available this cycle
//   out_ready                 - consumer accepts ALU output this cycle
//   alu_op_done               - ALU reports last cycle of the operation
//   alu_advance/regfile_en    - ALU step strobes (identical)
//   alu_* controls            - fields of the active request, zero in IDLE
//   done_valid/done_tag       - one-cycle completion pulse with request tag
//   timeout_err               - sticky: an operation exceeded TIMEOUT advances
// Handshake: a request transfers on a clk edge where req_valid && req_ready;
// req_ready depends only on registered state (pending entry free), never on
// req_valid, and the requester holds its fields stable until the transfer.
module alu_sequencer #(
    parameter int LOG2_NR  = 3,
    parameter int OP_BITS  = alu_pkg::OP_BITS,
    parameter int TAG_BITS = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_BITS-1:0]  req_op,
    input  logic [LOG2_NR-1:0]  req_reg1,
    input  logic [LOG2_NR-1:0]  req_reg2,
    input  logic                req_pair,
    input  logic                req_ext,
    input  logic                req_wr,
    input  logic [1:0]          req_flags,
    input  logic [TAG_BITS-1:0] req_tag,
    input  logic                mem_valid,
    input  logic                out_ready,
    input  logic                alu_op_done,
    output logic                alu_advance,
    output logic                alu_regfile_en,
    output logic [OP_BITS-1:0]  alu_operation,
    output logic [LOG2_NR-1:0]  alu_reg1,
    output logic [LOG2_NR-1:0]  alu_reg2,
    output logic                alu_pair_op,
    output logic                alu_external_arg2,
    output logic                alu_update_reg1,
    output logic                alu_update_carry_flags,
    output logic                alu_update_other_flags,
    output logic                done_valid,
    output logic [TAG_BITS-1:0] done_tag,
    output logic                timeout_err
);

    import alu_pkg::*;

    typedef struct packed {
        logic [OP_BITS-1:0]  op;
        logic [LOG2_NR-1:0]  reg1;
        logic [LOG2_NR-1:0]  reg2;
        logic                pair;
        logic                ext;
        logic                wr;
        logic [1:0]          flags;   // {carry, other}
        logic [TAG_BITS-1:0] tag;
    } req_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] adv_cnt;
    req_t       push_req;
    req_t       act;
    logic       pending_valid;
    logic       accept;
    logic       run;
    logic       advance;
    logic       last_adv;
    logic       end_op;

    assign push_req = '{op: req_op, reg1: req_reg1, reg2: req_reg2,
                        pair: req_pair, ext: req_ext, wr: req_wr,
                        flags: req_flags, tag: req_tag};

    assign accept = req_valid && req_ready;
    assign run    = (state == ST_RUN);

    // an operand from memory stalls the step until the memory word arrives
    assign advance  = run && (!act.ext || mem_valid) && out_ready;
    // this advance is the TIMEOUT-th one of the operation
    assign last_adv = (adv_cnt == CNT_LAST);
    // completion and timeout both retire the active request
    assign end_op   = advance && (alu_op_done || last_adv);

    alu_req_slot #(
        .W($bits(req_t))
    ) u_slot (
        .clk           (clk),
        .reset_n       (reset_n),
        .push          (accept),
        .push_data     (push_req),
        .pop           (end_op),
        .active_data   (act),
        .pending_valid (pending_valid),
        .ready         (req_ready)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (end_op && !pending_valid && !accept) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            adv_cnt     <= '0;
            done_valid  <= 1'b0;
            done_tag    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            done_valid <= advance && alu_op_done;
            if (advance && alu_op_done) begin
                done_tag <= act.tag;
            end
            if (advance && !alu_op_done && last_adv) begin
                timeout_err <= 1'b1;
            end
            // the next operation (if any) starts on the edge after end_op
            if (!run || end_op) begin
                adv_cnt <= '0;
            end else if (advance) begin
                adv_cnt <= adv_cnt + 4'd1;
            end
        end
    end

    assign alu_advance            = advance;
    assign alu_regfile_en         = advance;
    assign alu_operation          = run ? act.op   : '0;
    assign alu_reg1               = run ? act.reg1 : '0;
    assign alu_reg2               = run ? act.reg2 : '0;
    assign alu_pair_op            = run && act.pair;
    assign alu_external_arg2      = run && act.ext;
    assign alu_update_reg1        = run && act.wr;
    assign alu_update_carry_flags = run && act.flags[1];
    assign alu_update_other_flags = run && act.flags[0];

endmodule
